cpu_clk_switch_ctrl: RTL and testbench
======================================

Name: cpu_clk_switch_ctrl

Overview:
- Generates the CPU PHI2 clock and sequences switching between two modes.
- Slow mode: CPU clock follows the BBC 2MHz PHI0.
- Fast mode: CPU clock is derived from a high-speed clock selected by the CLK_HSCLK_EN / CLK_DIV_EN / CLK_DIV4NOT2 control bits.
- Any CPU cycle that must touch the BBC bus (host RAM, IO, non-remapped ROM) stretches phi1 and drops that cycle to slow mode, phase-aligned to BBC PHI0. Remapped/HIMEM cycles stay fast.

Parameters:
- SYNC_STAGES, 2, flops in the bbc_ck2_phi0 synchroniser (min 2).
- CNT_W, 3, width of the half-period counter.

Ports:
- hsclk  input  1  high-speed reference clock; all state is clocked on its rising edge.
- resetb  input  1  reset, asynchronous, active-low.
- bbc_ck2_phi0  input  1  BBC 2MHz PHI0, asynchronous to hsclk.
- fast_en  input  1  CLK_HSCLK_EN control bit.
- div_en  input  1  CLK_DIV_EN control bit.
- div4not2  input  1  CLK_DIV4NOT2 control bit.
- bbc_access  input  1  current CPU cycle needs the BBC bus; valid by end of CPU phi1.
- cpu_ck_phi2  output  1  CPU PHI2, registered.
- cpu_ck_phi1  output  1  inverse of cpu_ck_phi2, registered.
- fast_active  output  1  1 while in state FAST.
- stretching  output  1  1 while in state ALIGN.

Behaviour:
- Synchroniser: phi0_s is bbc_ck2_phi0 through SYNC_STAGES flops; phi0_d is phi0_s delayed one more flop.
  - rise0 = phi0_s & !phi0_d
  - fall0 = !phi0_s & phi0_d
- Half-period length H (clk cycles), sampled only at a FAST phase boundary:
  - div_en=0 → H=1
  - div_en=1, div4not2=0 → H=2
  - div_en=1, div4not2=1 → H=4
- States: SLOW, FAST, ALIGN. Reset state is SLOW.
- Reset values: cpu_ck_phi2=0, cpu_ck_phi1=1, cnt=0, sync flops=0, fast_active=0, stretching=0. Reset mid-operation forces these values immediately (asynchronous), including truncating a fast phase.
- SLOW:
  - Every clk, cpu_ck_phi2 <= phi0_s. Latency from the bbc_ck2_phi0 pin is SYNC_STAGES+1 clk.
  - On fall0 with fast_en=1: go to FAST, cpu_ck_phi2 <= 0, cnt <= 0, latch H.
  - fast_en is ignored at all other times in SLOW.
- FAST:
  - cnt increments each clk.
  - When cnt==H-1: cnt <= 0 and a phase boundary occurs.
  - Boundary with cpu_ck_phi2=1: drive 0 (start of phi1) and re-latch H.
  - Boundary with cpu_ck_phi2=0 (end of phi1): sample bbc_access and fast_en.
    - Both fast_en=1 and bbc_access=0: drive 1 and stay in FAST.
    - Otherwise: hold 0 and go to ALIGN.
  - H changes take effect only at the phase boundary that starts phi1, so every phase is glitch-free and at least 1 clk long.
- ALIGN:
  - cpu_ck_phi2 is held 0; bbc_access and fast_en are ignored.
  - rise0 → cpu_ck_phi2 <= 1, go to SLOW. CPU phi2 is then coincident with BBC phi2 (skew = sync latency).
  - If ALIGN is entered on the same clk as rise0, that rise0 is not consumed; wait for the next one.
- Return to fast: occurs at the first fall0 in SLOW with fast_en=1. One slow cycle is therefore the minimum cost of a bbc_access.
- cpu_ck_phi1 is always the registered complement of cpu_ck_phi2, from the same flop stage (no combinational inversion).
- fast_active is 1 iff the state is FAST. stretching is 1 iff the state is ALIGN.
- Simultaneous events:
  - fast_en dropping exactly at a fast phi1 boundary is treated as bbc_access=1 (go to ALIGN).
  - Control-bit changes while in SLOW or ALIGN are only seen at the next SLOW fall0.

Test Plan:
- Reset, then SLOW tracking: hsclk 32MHz, phi0 2MHz (8 clk per phase), fast_en=0 → cpu_ck_phi2 equals phi0 delayed 3 clk; fast_active=0; no extra edges over 100 BBC cycles.
- Fast entry: set fast_en=1, div_en=0 → at the first phi0 fall the state enters FAST; cpu_ck_phi2 toggles every clk (16MHz); fast_active=1 from that clk.
- Divider change mid-run: in FAST, set div_en=1, div4not2=1 → the change applies at the next phi1 start; phases become 4 clk; no phase shorter than 1 clk during the change; div4not2=0 → 2 clk phases.
- BBC access stretch: in FAST with H=1, raise bbc_access at end of phi1 → cpu_ck_phi2 held low (stretching=1) until synced phi0 rises; then one slow phi2 of 8 clk; FAST resumes at the next phi0 fall; total stretch ≤ 16+3 clk.
- Edge coincidence: arrange ALIGN entry on the same clk as rise0 → cpu_ck_phi2 stays low until the following rise0 (about 16 clk), with no runt high pulse.
- Async reset mid-FAST and mid-ALIGN: pulse resetb low for 1ns → cpu_ck_phi2=0 and cpu_ck_phi1=1 immediately; state SLOW; after release, tracks phi0 again within 3 clk.

Source files
------------

// File: rtl/cpu_clk_switch_ctrl.sv
// CPU PHI2 generator: tracks BBC PHI0 in slow mode, divides hsclk in fast
// mode, and stretches phi1 to re-align with PHI0 for BBC bus cycles.
module cpu_clk_switch_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 3
) (
    input  logic hsclk,
    input  logic resetb,
    input  logic bbc_ck2_phi0,
    input  logic fast_en,
    input  logic div_en,
    input  logic div4not2,
    input  logic bbc_access,
    output logic cpu_ck_phi2,
    output logic cpu_ck_phi1,
    output logic fast_active,
    output logic stretching
);

    typedef enum logic [1:0] {
        ST_SLOW,
        ST_FAST,
        ST_ALIGN
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_phi0_d;
    logic                   r_phi2;
    logic                   r_phi1;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       r_hm1;

    logic [CNT_W-1:0]       w_cnt_nxt;
    logic [CNT_W-1:0]       w_hm1_nxt;
    logic [CNT_W-1:0]       w_hsel;
    logic                   w_phi2_nxt;
    logic                   w_phi0_s;
    logic                   w_rise0;
    logic                   w_fall0;
    logic                   w_bound;

    assign w_phi0_s = r_sync[SYNC_STAGES-1];
    assign w_rise0  = w_phi0_s & ~r_phi0_d;
    assign w_fall0  = ~w_phi0_s & r_phi0_d;
    assign w_bound  = (r_cnt == r_hm1);

    // half-period minus one, from the divider control bits
    assign w_hsel = !div_en  ? CNT_W'(0) :
                    div4not2 ? CNT_W'(3) : CNT_W'(1);

    assign cpu_ck_phi2 = r_phi2;
    assign cpu_ck_phi1 = r_phi1;
    assign fast_active = (r_state == ST_FAST);
    assign stretching  = (r_state == ST_ALIGN);

    // PHI0 synchroniser plus one delay flop for edge detection
    always_ff @(posedge hsclk or negedge resetb) begin
        if (!resetb) begin
            r_sync   <= '0;
            r_phi0_d <= 1'b0;
        end else begin
            r_sync   <= {r_sync[SYNC_STAGES-2:0], bbc_ck2_phi0};
            r_phi0_d <= w_phi0_s;
        end
    end

    // state, counter, latched half-period and both clock phases
    always_ff @(posedge hsclk or negedge resetb) begin
        if (!resetb) begin
            r_state <= ST_SLOW;
            r_cnt   <= '0;
            r_hm1   <= '0;
            r_phi2  <= 1'b0;
            r_phi1  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_hm1   <= w_hm1_nxt;
            r_phi2  <= w_phi2_nxt;
            r_phi1  <= ~w_phi2_nxt;
        end
    end

    // next-state, phase and counter decisions
    always_comb begin
        w_state_nxt = r_state;
        w_phi2_nxt  = r_phi2;
        w_cnt_nxt   = r_cnt;
        w_hm1_nxt   = r_hm1;
        unique case (r_state)
            ST_SLOW: begin
                w_phi2_nxt = w_phi0_s;
                if (w_fall0 && fast_en) begin
                    w_state_nxt = ST_FAST;
                    w_phi2_nxt  = 1'b0;
                    w_cnt_nxt   = '0;
                    w_hm1_nxt   = w_hsel;
                end
            end
            ST_FAST: begin
                if (w_bound) begin
                    w_cnt_nxt = '0;
                    if (r_phi2) begin
                        w_phi2_nxt = 1'b0;
                        w_hm1_nxt  = w_hsel;
                    end else if (fast_en && !bbc_access) begin
                        w_phi2_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ST_ALIGN;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_ALIGN: begin
                if (w_rise0) begin
                    w_phi2_nxt  = 1'b1;
                    w_state_nxt = ST_SLOW;
                end
            end
            default: begin
                w_state_nxt = ST_SLOW;
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_clk_switch_ctrl.sv
// Bench for cpu_clk_switch_ctrl: random PHI0 jitter, control bits and
// bus accesses compared each clk against a countdown-based phase model.
module tb_cpu_clk_switch_ctrl;

    localparam int SYNC = 2;
    localparam int M_SLOW  = 0;
    localparam int M_FAST  = 1;
    localparam int M_ALIGN = 2;

    logic hsclk;
    logic resetb;
    logic bbc_ck2_phi0;
    logic fast_en;
    logic div_en;
    logic div4not2;
    logic bbc_access;
    logic cpu_ck_phi2;
    logic cpu_ck_phi1;
    logic fast_active;
    logic stretching;

    int n_chk;
    int n_err;

    int   m_mode  = M_SLOW;
    logic m_phi2  = 1'b0;
    int   m_left  = 0;
    int   m_h     = 1;
    logic hist [0:SYNC];
    int   n_coinc = 0;
    int   n_fast_h [1:4];

    cpu_clk_switch_ctrl #(
        .SYNC_STAGES(SYNC),
        .CNT_W      (3)
    ) dut (
        .hsclk       (hsclk),
        .resetb      (resetb),
        .bbc_ck2_phi0(bbc_ck2_phi0),
        .fast_en     (fast_en),
        .div_en      (div_en),
        .div4not2    (div4not2),
        .bbc_access  (bbc_access),
        .cpu_ck_phi2 (cpu_ck_phi2),
        .cpu_ck_phi1 (cpu_ck_phi1),
        .fast_active (fast_active),
        .stretching  (stretching)
    );

    initial begin
        hsclk = 1'b0;
        forever #5 hsclk = ~hsclk;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s t=%0t got %0h exp %0h", tag, $time, got, exp);
        end
    endtask

    function automatic int half_len();
        if (!div_en) return 1;
        if (div4not2) return 4;
        return 2;
    endfunction

    task automatic model_reset();
        m_mode = M_SLOW;
        m_phi2 = 1'b0;
        m_left = 0;
        for (int i = 0; i <= SYNC; i++) hist[i] = 1'b0;
    endtask

    // one hsclk edge of the reference: PHI0 is seen SYNC edges late,
    // fast phases are timed by counting down the remaining clocks
    task automatic model_step();
        logic s;
        logic d;
        logic rise;
        logic fall;
        s    = hist[SYNC-1];
        d    = hist[SYNC];
        rise = s && !d;
        fall = !s && d;
        case (m_mode)
            M_SLOW: begin
                if (fall && fast_en) begin
                    m_mode = M_FAST;
                    m_phi2 = 1'b0;
                    m_h    = half_len();
                    m_left = m_h;
                end else begin
                    m_phi2 = s;
                end
            end
            M_FAST: begin
                n_fast_h[m_h]++;
                m_left--;
                if (m_left == 0) begin
                    if (m_phi2) begin
                        m_phi2 = 1'b0;
                        m_h    = half_len();
                        m_left = m_h;
                    end else if (fast_en && !bbc_access) begin
                        m_phi2 = 1'b1;
                        m_left = m_h;
                    end else begin
                        m_mode = M_ALIGN;
                        if (rise) n_coinc++;
                    end
                end
            end
            default: begin
                if (rise) begin
                    m_phi2 = 1'b1;
                    m_mode = M_SLOW;
                end
            end
        endcase
        for (int i = SYNC; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = bbc_ck2_phi0;
    endtask

    initial begin
        model_reset();
        for (int i = 1; i <= 4; i++) n_fast_h[i] = 0;
        forever begin
            @(posedge hsclk or negedge resetb);
            if (!resetb) model_reset();
            else model_step();
        end
    end

    task automatic reset_pulse(input string tag);
        #1 resetb = 1'b0;
        #1;
        chk({tag, "_phi2"}, 32'(cpu_ck_phi2), 32'd0);
        chk({tag, "_phi1"}, 32'(cpu_ck_phi1), 32'd1);
        chk({tag, "_fast"}, 32'(fast_active), 32'd0);
        chk({tag, "_strc"}, 32'(stretching), 32'd0);
        #1 resetb = 1'b1;
    endtask

    initial begin
        int  half_left;
        bit  did_rf;
        bit  did_ra;
        n_chk        = 0;
        n_err        = 0;
        resetb       = 1'b0;
        bbc_ck2_phi0 = 1'b0;
        fast_en      = 1'b0;
        div_en       = 1'b0;
        div4not2     = 1'b0;
        bbc_access   = 1'b0;
        half_left    = 8;
        did_rf       = 1'b0;
        did_ra       = 1'b0;

        repeat (3) @(negedge hsclk);
        chk("rst_phi2", 32'(cpu_ck_phi2), 32'd0);
        chk("rst_phi1", 32'(cpu_ck_phi1), 32'd1);
        chk("rst_fast", 32'(fast_active), 32'd0);
        chk("rst_strc", 32'(stretching), 32'd0);
        resetb = 1'b1;

        for (int c = 0; c < 8000; c++) begin
            @(negedge hsclk);
            chk("phi2", 32'(cpu_ck_phi2), 32'(m_phi2));
            chk("phi1", 32'(cpu_ck_phi1), 32'(!m_phi2));
            chk("fast", 32'(fast_active), 32'(m_mode == M_FAST));
            chk("strc", 32'(stretching), 32'(m_mode == M_ALIGN));

            if (c > 2000 && !did_rf && m_mode == M_FAST) begin
                reset_pulse("rst_fast");
                did_rf = 1'b1;
            end else if (c > 4000 && !did_ra && m_mode == M_ALIGN) begin
                reset_pulse("rst_align");
                did_ra = 1'b1;
            end

            half_left--;
            if (half_left == 0) begin
                bbc_ck2_phi0 = ~bbc_ck2_phi0;
                half_left = (c < 1600) ? 8 : int'($urandom_range(7, 9));
            end

            if (c < 1600) begin
                fast_en    = 1'b0;
                bbc_access = 1'b0;
            end else if (c < 2400) begin
                fast_en    = 1'b1;
                bbc_access = 1'b0;
                if ($urandom_range(0, 40) == 0) begin
                    div_en   = 1'($urandom_range(0, 1));
                    div4not2 = 1'($urandom_range(0, 1));
                end
            end else begin
                fast_en    = ($urandom_range(0, 31) != 0);
                bbc_access = ($urandom_range(0, 7) == 0);
                if ($urandom_range(0, 63) == 0) begin
                    div_en   = 1'($urandom_range(0, 1));
                    div4not2 = 1'($urandom_range(0, 1));
                end
            end
        end

        chk("did_rst_fast", 32'(did_rf), 32'd1);
        chk("did_rst_align", 32'(did_ra), 32'd1);
        chk("seen_coinc", 32'(n_coinc > 0), 32'd1);
        chk("seen_h1", 32'(n_fast_h[1] > 0), 32'd1);
        chk("seen_h2", 32'(n_fast_h[2] > 0), 32'd1);
        chk("seen_h4", 32'(n_fast_h[4] > 0), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
